past_assert_client: RTL and testbench

PAST_ASSERT_CLIENT -- requirements
Module: past_assert_client

---
 rtl/past_assert_client.sv | 146 ++++++++++++++
 tb/tb_past_assert_client.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/past_assert_client.sv
// Client that runs a fixed number of start/measure trials against a busy server,
// counting trials whose busy pulse is not exactly MAX_AMOUNT valid cycles long.
module past_assert_client #(
    parameter int F_TESTID   = 9999,
    parameter int MAX_AMOUNT = 22,
    parameter int NUM_TRIALS = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        go__ENA,
    output logic        go__RDY,
    output logic        startSignal__ENA,
    input  logic        startSignal__RDY,
    input  logic        busy,
    input  logic        busy__RDY,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  trial_count,
    output logic [15:0] cycles_last,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        MEASURE = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [15:0] LIMIT    = 16'(2 * MAX_AMOUNT);
    localparam logic [15:0] TARGET   = 16'(MAX_AMOUNT);
    localparam logic [7:0]  TRIALS   = 8'(NUM_TRIALS);
    localparam logic [7:0]  GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

    // Reject parameter values the counters cannot represent.
    if (MAX_AMOUNT < 1 || MAX_AMOUNT > 32767) begin : g_bad_max_amount
        $error("MAX_AMOUNT must be in 1..32767");
    end
    if (NUM_TRIALS < 1 || NUM_TRIALS > 255) begin : g_bad_num_trials
        $error("NUM_TRIALS must be in 1..255");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255 || F_TESTID < 0) begin : g_bad_gap_or_id
        $error("GAP_CYCLES must be in 0..255 and F_TESTID non-negative");
    end

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] busy_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic        go_accept_s;
    logic        trial_end_s;
    logic        cnt_inc_s;
    logic        viol_s;
    logic [15:0] trial_len_s;
    logic [7:0]  trial_inc_s;

    assign go__RDY          = (state_r == IDLE) || (state_r == DONE);
    assign startSignal__ENA = (state_r == ISSUE) && startSignal__RDY;
    assign done             = (state_r == DONE);
    assign pass             = done && (err_count == 8'd0) && !proto_err;
    assign go_accept_s      = go__RDY && go__ENA;
    assign trial_inc_s      = trial_count + 8'd1;
    // Server claims ready while still reporting a valid busy: protocol breach.
    assign viol_s           = (state_r != IDLE) && busy__RDY && busy && startSignal__RDY;

    // Next-state and trial-end decode.
    always_comb begin
        state_nx_s  = state_r;
        trial_end_s = 1'b0;
        cnt_inc_s   = 1'b0;
        trial_len_s = busy_cnt_r;
        case (state_r)
            IDLE, DONE: begin
                if (go__ENA) state_nx_s = ISSUE;
                else         state_nx_s = state_r;
            end
            ISSUE: begin
                if (startSignal__RDY) state_nx_s = MEASURE;
                else                  state_nx_s = ISSUE;
            end
            MEASURE: begin
                if (busy__RDY && !busy) begin
                    trial_end_s = 1'b1;
                end else if (busy__RDY && ((busy_cnt_r + 16'd1) >= LIMIT)) begin
                    trial_end_s = 1'b1;
                    trial_len_s = LIMIT;
                end else if (busy__RDY) begin
                    cnt_inc_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b0;
                end
                if (!trial_end_s)                 state_nx_s = MEASURE;
                else if (HAS_GAP)                 state_nx_s = GAP;
                else if (trial_inc_s == TRIALS)   state_nx_s = DONE;
                else                              state_nx_s = ISSUE;
            end
            GAP: begin
                if (gap_cnt_r != GAP_LAST)        state_nx_s = GAP;
                else if (trial_count == TRIALS)   state_nx_s = DONE;
                else                              state_nx_s = ISSUE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, counters and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            busy_cnt_r  <= 16'd0;
            gap_cnt_r   <= 8'd0;
            err_count   <= 8'd0;
            trial_count <= 8'd0;
            cycles_last <= 16'd0;
            proto_err   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (go_accept_s) begin
                busy_cnt_r  <= 16'd0;
                err_count   <= 8'd0;
                trial_count <= 8'd0;
                cycles_last <= 16'd0;
            end else if (state_r == ISSUE) begin
                busy_cnt_r <= 16'd0;
            end else if (trial_end_s) begin
                cycles_last <= trial_len_s;
                trial_count <= trial_inc_s;
                gap_cnt_r   <= 8'd0;
                if ((trial_len_s != TARGET) && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (cnt_inc_s) begin
                busy_cnt_r <= busy_cnt_r + 16'd1;
            end else if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end
            if (go_accept_s)  proto_err <= 1'b0;
            else if (viol_s)  proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_past_assert_client.sv
// Self-checking bench for past_assert_client: a scripted busy server, a table of
// fixed runs, hand-written corner sequences and randomized runs against a model.
module tb_past_assert_client;

    localparam int MAXA  = 22;
    localparam int NT    = 4;
    localparam int LIMIT = 2 * MAXA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go_ena = 1'b0;
    logic        go_rdy, ena, srdy, busy, done, pass, proto;
    logic        brdy = 1'b1;
    logic [7:0]  errc, trc;
    logic [15:0] clast;

    past_assert_client #(.F_TESTID(9999), .MAX_AMOUNT(MAXA), .NUM_TRIALS(NT), .GAP_CYCLES(2)) dut (
        .CLK(clk), .RST(rst),
        .go__ENA(go_ena), .go__RDY(go_rdy),
        .startSignal__ENA(ena), .startSignal__RDY(srdy),
        .busy(busy), .busy__RDY(brdy),
        .done(done), .pass(pass),
        .err_count(errc), .trial_count(trc),
        .cycles_last(clast), .proto_err(proto)
    );

    always #5 clk = ~clk;

    // Server: each start loads the scripted busy length, counted in valid cycles.
    int   lens [NT];
    int   srv_cnt = 0;
    int   run_base = 0;
    logic rdy_block = 1'b0, force_viol = 1'b0, brdy_rand = 1'b0, brdy_low = 1'b0;

    assign busy = (srv_cnt != 0) || force_viol;
    assign srdy = ((srv_cnt == 0) || force_viol) && !rdy_block;

    int cyc = 0, en_cnt = 0, bad_ena = 0, pass_bad = 0;
    int ena_t [4096];

    always @(posedge clk) begin
        int k;
        k = en_cnt - run_base;
        if (ena) srv_cnt <= (k >= 0 && k < NT) ? lens[k] : MAXA;
        else if (brdy && srv_cnt > 0) srv_cnt <= srv_cnt - 1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ena) begin
            if (en_cnt < 4096) ena_t[en_cnt] <= cyc;
            en_cnt <= en_cnt + 1;
        end
        if (ena && !srdy) bad_ena <= bad_ena + 1;
    end

    always @(negedge clk) begin
        if (brdy_low)       brdy = 1'b0;
        else if (brdy_rand) brdy = ($urandom_range(0, 3) != 0);
        else                brdy = 1'b1;
    end

    int total = 0, passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d;
    endtask

    task automatic launch(input string tag);
        chk({tag, ".go_rdy"}, go_rdy, 1);
        run_base = en_cnt;
        go_ena = 1'b1;
        tick();
        go_ena = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 6000) begin
            if (pass) pass_bad++;
            tick();
            n++;
        end
        if (!done) chk({tag, ".done_timeout"}, 0, 1);
    endtask

    // Reference: length seen = min(server length, 2*MAX); any length != MAX is an error.
    function automatic void model(output int e_err, output int e_last);
        int seen;
        e_err = 0;
        e_last = 0;
        for (int i = 0; i < NT; i++) begin
            seen = (lens[i] > LIMIT) ? LIMIT : lens[i];
            if (seen != MAXA) e_err++;
            e_last = seen;
        end
    endfunction

    task automatic check_run(input string tag, input int e_err, input int e_last, input bit e_pass);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".pass"}, pass, e_pass);
        chk({tag, ".err_count"}, errc, e_err);
        chk({tag, ".trial_count"}, trc, NT);
        chk({tag, ".cycles_last"}, clast, e_last);
        chk({tag, ".proto_err"}, proto, 0);
        chk({tag, ".starts"}, en_cnt - run_base, NT);
    endtask

    typedef struct {
        int l0, l1, l2, l3;
        bit rnd;
        int e_err;
        int e_last;
        bit e_pass;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   e_err, e_last, n, seen;

        tbl[0] = '{22, 22, 22, 22, 1'b0, 0, 22, 1'b1};
        tbl[1] = '{22, 21, 22, 22, 1'b1, 1, 22, 1'b0};
        tbl[2] = '{22, 22, 22, 50, 1'b0, 1, 44, 1'b0};
        tbl[3] = '{ 0, 22, 22, 22, 1'b1, 1, 22, 1'b0};
        tbl[4] = '{23,  0, 44, 21, 1'b1, 4, 21, 1'b0};
        tbl[5] = '{ 1, 22, 22, 43, 1'b0, 2, 43, 1'b0};
        set_lens(MAXA, MAXA, MAXA, MAXA);

        repeat (3) tick();
        rst = 1'b0;
        chk("reset.go_rdy", go_rdy, 1);
        chk("reset.ena", ena, 0);
        chk("reset.done", done, 0);
        chk("reset.pass", pass, 0);
        chk("reset.err_count", errc, 0);
        chk("reset.trial_count", trc, 0);
        chk("reset.cycles_last", clast, 0);
        chk("reset.proto_err", proto, 0);

        // Golden server: starts every 1 + 23 + 2 cycles.
        launch("golden");
        wait_done("golden");
        check_run("golden", 0, 22, 1'b1);
        for (int i = 1; i < NT; i++)
            chk("golden.spacing", ena_t[run_base + i] - ena_t[run_base + i - 1], 26);

        for (int v = 0; v < 6; v++) begin
            set_lens(tbl[v].l0, tbl[v].l1, tbl[v].l2, tbl[v].l3);
            brdy_rand = tbl[v].rnd;
            launch($sformatf("table%0d", v));
            wait_done($sformatf("table%0d", v));
            brdy_rand = 1'b0;
            check_run($sformatf("table%0d", v), tbl[v].e_err, tbl[v].e_last, tbl[v].e_pass);
        end

        // Busy stuck high on trial 2: timeout at 2*MAX, then ISSUE stalls.
        set_lens(22, 100, 22, 22);
        launch("stuck");
        n = 0;
        while (trc != 8'd2 && n < 2000) begin tick(); n++; end
        chk("stuck.cycles_last", clast, LIMIT);
        chk("stuck.err_count", errc, 1);
        wait_done("stuck");
        check_run("stuck", 1, 22, 1'b0);

        // Ready held low 10 cycles in ISSUE.
        set_lens(22, 22, 22, 22);
        rdy_block = 1'b1;
        launch("rdy_low");
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ena) seen++;
            tick();
        end
        chk("rdy_low.no_ena", seen, 0);
        rdy_block = 1'b0;
        #1;
        chk("rdy_low.ena_after", ena, 1);
        wait_done("rdy_low");
        check_run("rdy_low", 0, 22, 1'b1);

        // Protocol breach forced in DONE; ignored while busy__RDY is low.
        brdy_low = 1'b1;
        tick();
        force_viol = 1'b1;
        tick();
        force_viol = 1'b0;
        chk("proto.masked", proto, 0);
        brdy_low = 1'b0;
        force_viol = 1'b1;
        tick();
        force_viol = 1'b0;
        chk("proto.set", proto, 1);
        chk("proto.pass", pass, 0);
        repeat (3) tick();
        chk("proto.sticky", proto, 1);
        launch("proto");
        chk("proto.cleared", proto, 0);
        wait_done("proto");
        check_run("proto", 0, 22, 1'b1);

        // Reset in MEASURE of trial 3, then a fresh run.
        launch("midrst");
        n = 0;
        while ((en_cnt - run_base) < 3 && n < 2000) begin tick(); n++; end
        repeat (5) tick();
        chk("midrst.before_trials", trc, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.go_rdy", go_rdy, 1);
        chk("midrst.ena", ena, 0);
        chk("midrst.done", done, 0);
        chk("midrst.pass", pass, 0);
        chk("midrst.err_count", errc, 0);
        chk("midrst.trial_count", trc, 0);
        chk("midrst.cycles_last", clast, 0);
        chk("midrst.proto_err", proto, 0);
        n = en_cnt;
        repeat (3) tick();
        chk("midrst.no_start", en_cnt - n, 0);
        launch("midrst_fresh");
        wait_done("midrst_fresh");
        check_run("midrst_fresh", 0, 22, 1'b1);

        // Randomized runs checked against the model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NT; i++) begin
                case ($urandom_range(0, 5))
                    0: lens[i] = 22;
                    1: lens[i] = 21;
                    2: lens[i] = 23;
                    3: lens[i] = 0;
                    4: lens[i] = $urandom_range(0, 60);
                    default: lens[i] = 22;
                endcase
            end
            brdy_rand = $urandom_range(0, 1);
            model(e_err, e_last);
            launch($sformatf("rand%0d", r));
            wait_done($sformatf("rand%0d", r));
            brdy_rand = 1'b0;
            check_run($sformatf("rand%0d", r), e_err, e_last, e_err == 0);
        end

        chk("ena_without_rdy", bad_ena, 0);
        chk("pass_without_done", pass_bad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
